fifo_byte_serializer: RTL and testbench

- Downstream consumer of the 32-bit sync FIFO. Pops one word at a time via the FIFO read port and emits it as a stream of OUT_W-bit beats on a valid/ready interface, MSB beat first.
- Sits between the FIFO and the byte-wide transmit/link stage.
- Also maintains a running count of fully transmitted words for status.

---
 rtl/fifo_byte_serializer.sv | 113 +++++++++++
 tb/tb_fifo_byte_serializer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_byte_serializer.sv
// Pops 32-bit words from a sync FIFO and replays each as NBEATS valid/ready
// beats, MSB beat first, while counting fully delivered words.
module fifo_byte_serializer #(
  parameter int DATA_W = 32,
  parameter int OUT_W  = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              fifo_empty,
  output logic              fifo_r_en,
  input  logic [DATA_W-1:0] fifo_data,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic [CNT_W-1:0]  words_sent
);

  localparam int NBEATS = DATA_W / OUT_W;
  localparam int BEAT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NBEATS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RD,
    S_CAP,
    S_SEND
  } state_e;

  state_e              state_q, state_d;
  logic                fifo_r_en_q, fifo_r_en_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic                out_valid_q, out_valid_d;
  logic [CNT_W-1:0]    words_sent_q, words_sent_d;
  logic                accept;
  logic                at_last;

  assign accept  = out_valid_q && out_ready;
  assign at_last = (beat_q == LAST_BEAT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      fifo_r_en_q  <= 1'b0;
      shreg_q      <= '0;
      beat_q       <= '0;
      out_valid_q  <= 1'b0;
      words_sent_q <= '0;
    end else begin
      state_q      <= state_d;
      fifo_r_en_q  <= fifo_r_en_d;
      shreg_q      <= shreg_d;
      beat_q       <= beat_d;
      out_valid_q  <= out_valid_d;
      words_sent_q <= words_sent_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    fifo_r_en_d  = 1'b0;
    shreg_d      = shreg_q;
    beat_d       = beat_q;
    out_valid_d  = out_valid_q;
    words_sent_d = words_sent_q;

    unique case (state_q)
      S_IDLE: begin
        // fifo_empty is only looked at here, so a pop can never hit an empty FIFO
        if (en && !fifo_empty) begin
          fifo_r_en_d = 1'b1;
          state_d     = S_RD;
        end
      end
      S_RD: begin
        state_d = S_CAP;
      end
      S_CAP: begin
        shreg_d     = fifo_data;
        beat_d      = '0;
        out_valid_d = 1'b1;
        state_d     = S_SEND;
      end
      S_SEND: begin
        if (accept) begin
          if (at_last) begin
            out_valid_d  = 1'b0;
            words_sent_d = words_sent_q + CNT_W'(1);
            state_d      = S_IDLE;
          end else begin
            shreg_d = shreg_q << OUT_W;
            beat_d  = beat_q + BEAT_W'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign fifo_r_en  = fifo_r_en_q;
  assign out_data   = shreg_q[DATA_W-1 -: OUT_W];
  assign out_valid  = out_valid_q;
  assign out_last   = out_valid_q && at_last;
  assign busy       = (state_q != S_IDLE);
  assign words_sent = words_sent_q;

endmodule

// File: tb/tb_fifo_byte_serializer.sv
// Directed bench for fifo_byte_serializer with a behavioural FIFO model;
// CNT_W is reduced to 4 so the word counter wrap is reachable quickly.
module tb_fifo_byte_serializer;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        fifo_empty;
  logic        fifo_r_en;
  logic [31:0] fifo_data = '0;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        busy;
  logic [3:0]  words_sent;

  always #5 clk = ~clk;

  fifo_byte_serializer #(
    .DATA_W(32),
    .OUT_W (8),
    .CNT_W (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .fifo_empty (fifo_empty),
    .fifo_r_en  (fifo_r_en),
    .fifo_data  (fifo_data),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .busy       (busy),
    .words_sent (words_sent)
  );

  logic [31:0] mem [0:63];
  int wr = 0;
  int rd = 0;
  int pop_cnt = 0;
  int roe = 0;
  int cyc = 0;
  int pop_cyc [0:63];

  assign fifo_empty = (wr == rd);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_r_en) begin
      if (wr == rd) begin
        roe <= roe + 1;
      end else begin
        fifo_data <= mem[rd];
        rd        <= rd + 1;
      end
      pop_cyc[pop_cnt] <= cyc;
      pop_cnt          <= pop_cnt + 1;
    end
  end

  int checks = 0;
  int errors = 0;
  int exp_ws = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] w);
    mem[wr] = w;
    wr = wr + 1;
  endtask

  // Collect one word; optional stall of sl cycles at beat sb, optional en drop at beat edb.
  task automatic collect(input logic [7:0] e0, input logic [7:0] e1,
                         input logic [7:0] e2, input logic [7:0] e3,
                         input int sb, input int sl, input int edb);
    logic [7:0] e [4];
    int n;
    int p0;
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    chk("valid_timeout", {31'd0, out_valid}, 32'd1);
    if (!out_valid) return;
    p0 = pop_cnt;
    for (int b = 0; b < 4; b++) begin
      if (b == edb) en = 1'b0;
      if (b == sb) begin
        for (int k = 0; k < sl; k++) begin
          out_ready = 1'b0;
          tick();
          chk("stall_data", {24'd0, out_data}, {24'd0, e[b]});
          chk("stall_valid", {31'd0, out_valid}, 32'd1);
          chk("stall_last", {31'd0, out_last}, {31'd0, (b == 3)});
        end
      end
      out_ready = 1'b1;
      chk("beat_valid", {31'd0, out_valid}, 32'd1);
      chk("beat_data", {24'd0, out_data}, {24'd0, e[b]});
      chk("beat_last", {31'd0, out_last}, {31'd0, (b == 3)});
      tick();
    end
    chk("end_valid", {31'd0, out_valid}, 32'd0);
    exp_ws = (exp_ws + 1) % 16;
    chk("words_sent", {28'd0, words_sent}, exp_ws);
    chk("no_extra_pop", pop_cnt, p0);
  endtask

  typedef struct {
    logic [31:0] word;
    int          stall_beat;
    int          stall_len;
    logic [7:0]  exp [4];
  } vec_t;

  vec_t vecs [6];

  task automatic set_vec(input int i, input logic [31:0] w, input int sb, input int sl,
                         input logic [7:0] e0, input logic [7:0] e1,
                         input logic [7:0] e2, input logic [7:0] e3);
    vecs[i].word       = w;
    vecs[i].stall_beat = sb;
    vecs[i].stall_len  = sl;
    vecs[i].exp[0] = e0; vecs[i].exp[1] = e1; vecs[i].exp[2] = e2; vecs[i].exp[3] = e3;
  endtask

  initial begin
    int pb;
    set_vec(0, 32'hA1B2C3D4, -1, 0, 8'hA1, 8'hB2, 8'hC3, 8'hD4);
    set_vec(1, 32'hA1B2C3D4,  1, 5, 8'hA1, 8'hB2, 8'hC3, 8'hD4);
    set_vec(2, 32'h00000000,  2, 1, 8'h00, 8'h00, 8'h00, 8'h00);
    set_vec(3, 32'hFFFFFFFF,  3, 2, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
    set_vec(4, 32'h80000001,  0, 3, 8'h80, 8'h00, 8'h00, 8'h01);
    set_vec(5, 32'h12345678, -1, 0, 8'h12, 8'h34, 8'h56, 8'h78);

    rst = 1'b0;
    en = 1'b1;
    out_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("rst_r_en", {31'd0, fifo_r_en}, 32'd0);
      chk("rst_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_ws", {28'd0, words_sent}, 32'd0);
    end
    chk("rst_data", {24'd0, out_data}, 32'd0);
    chk("rst_last", {31'd0, out_last}, 32'd0);
    #2 rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_r_en", {31'd0, fifo_r_en}, 32'd0);
      chk("idle_busy", {31'd0, busy}, 32'd0);
    end

    // latency: pop pulse one edge after push, valid three edges after
    out_ready = 1'b1;
    push(32'hA1B2C3D4);
    tick();
    chk("lat_r_en1", {31'd0, fifo_r_en}, 32'd1);
    chk("lat_busy", {31'd0, busy}, 32'd1);
    chk("lat_valid1", {31'd0, out_valid}, 32'd0);
    tick();
    chk("lat_r_en2", {31'd0, fifo_r_en}, 32'd0);
    chk("lat_valid2", {31'd0, out_valid}, 32'd0);
    tick();
    chk("lat_valid3", {31'd0, out_valid}, 32'd1);
    collect(8'hA1, 8'hB2, 8'hC3, 8'hD4, -1, 0, -1);

    for (int i = 0; i < 6; i++) begin
      push(vecs[i].word);
      collect(vecs[i].exp[0], vecs[i].exp[1], vecs[i].exp[2], vecs[i].exp[3],
              vecs[i].stall_beat, vecs[i].stall_len, -1);
    end

    // four-word burst, pops 7 cycles apart
    pb = pop_cnt;
    push(32'h01020304); push(32'h05060708); push(32'h090A0B0C); push(32'h0D0E0F10);
    collect(8'h01, 8'h02, 8'h03, 8'h04, -1, 0, -1);
    collect(8'h05, 8'h06, 8'h07, 8'h08, -1, 0, -1);
    collect(8'h09, 8'h0A, 8'h0B, 8'h0C, -1, 0, -1);
    collect(8'h0D, 8'h0E, 8'h0F, 8'h10, -1, 0, -1);
    for (int i = 0; i < 3; i++)
      chk("burst_spacing", pop_cyc[pb + i + 1] - pop_cyc[pb + i], 32'd7);
    for (int i = 0; i < 10; i++) tick();
    chk("burst_pops", pop_cnt - pb, 32'd4);
    chk("read_on_empty", roe, 32'd0);
    chk("burst_idle", {31'd0, busy}, 32'd0);

    // en dropped mid-word
    pb = pop_cnt;
    push(32'hCAFEBABE); push(32'h5A5AA5A5);
    collect(8'hCA, 8'hFE, 8'hBA, 8'hBE, -1, 0, 1);
    for (int i = 0; i < 10; i++) tick();
    chk("en_gate_pops", pop_cnt - pb, 32'd1);
    chk("en_gate_busy", {31'd0, busy}, 32'd0);
    chk("en_gate_valid", {31'd0, out_valid}, 32'd0);
    en = 1'b1;
    collect(8'h5A, 8'h5A, 8'hA5, 8'hA5, -1, 0, -1);

    // asynchronous reset between edges during the first beat
    pb = pop_cnt;
    push(32'hDEADBEEF); push(32'h11223344);
    for (int i = 0; i < 20 && !out_valid; i++) tick();
    chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("arst_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_data", {24'd0, out_data}, 32'd0);
    chk("arst_last", {31'd0, out_last}, 32'd0);
    chk("arst_ws", {28'd0, words_sent}, 32'd0);
    exp_ws = 0;
    repeat (2) begin
      @(posedge clk);
      #2;
      chk("arst_r_en", {31'd0, fifo_r_en}, 32'd0);
    end
    rst = 1'b1;
    collect(8'h11, 8'h22, 8'h33, 8'h44, -1, 0, -1);
    chk("arst_pops", pop_cnt - pb, 32'd2);

    // counter wrap at CNT_W=4
    for (int i = 0; i < 16; i++) begin
      push({8'(4 * i), 8'(4 * i + 1), 8'(4 * i + 2), 8'(4 * i + 3)});
      collect(8'(4 * i), 8'(4 * i + 1), 8'(4 * i + 2), 8'(4 * i + 3), -1, 0, -1);
    end
    chk("wrap_ws", {28'd0, words_sent}, 32'd1);
    for (int i = 0; i < 15; i++) begin
      push(32'h00FF00FF);
      collect(8'h00, 8'hFF, 8'h00, 8'hFF, -1, 0, -1);
    end
    chk("wrap_zero", {28'd0, words_sent}, 32'd0);
    push(32'h76543210);
    collect(8'h76, 8'h54, 8'h32, 8'h10, -1, 0, -1);
    chk("wrap_one", {28'd0, words_sent}, 32'd1);
    chk("final_roe", roe, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
